// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out bundle between a byte producer and the UART transmitter.
// The producer holds the master modport; the transmitter holds the slave modport.
interface uart_tx_serializer_if;
  logic [7:0] data_in;
  logic       enable_in;
  logic       tx_out;
  logic       busy_out;
  logic       tick_out;

  modport master (
    output data_in,
    output enable_in,
    input  tx_out,
    input  busy_out,
    input  tick_out
  );

  modport slave (
    input  data_in,
    input  enable_in,
    output tx_out,
    output busy_out,
    output tick_out
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a built-in oversample tick divider.
//
// state   | meaning
// S_IDLE  | line high, waiting for enable_in
// S_START | driving the start bit (0)
// S_DATA  | driving data bits LSB first, bit_idx_q selects which one
// S_STOP  | driving the stop bit (1)
module uart_tx_serializer #(
  parameter int BAUDRATE_HZ = 115_200,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  uart_tx_serializer_if.slave bus
);

  localparam longint TICK_HZ = longint'(BAUDRATE_HZ) * longint'(SAMPLE_RATE);
  localparam longint DIV_RAW = (longint'(CLK_HZ) + TICK_HZ / 2) / TICK_HZ;
  localparam int     DIV     = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
  localparam int     DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int     SR_W    = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SR_W-1:0]  SR_LAST  = SR_W'(SAMPLE_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SR_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             bit_end;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tick       = (div_q == DIV_LAST);
    bit_end    = tick && (tick_cnt_q == SR_LAST);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;

    if (state_q == S_IDLE) begin
      tx_d = 1'b1;
      if (bus.enable_in) begin
        // Restart the divider here so every bit edge is an exact multiple of DIV from acceptance.
        shift_d    = bus.data_in;
        tx_d       = 1'b0;
        state_d    = S_START;
        div_d      = '0;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
    end else begin
      if (tick) begin
        tick_cnt_d = bit_end ? '0 : tick_cnt_q + SR_W'(1);
      end
      case (state_q)
        S_START: begin
          if (bit_end) begin
            tx_d      = shift_q[0];
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_out   = tx_q;
  assign bus.busy_out = (state_q != S_IDLE);
  assign bus.tick_out = tick;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed frames plus random bytes, checked against a
// bit-period waveform model. A reduced clock keeps frames short (DIV=5, 80-clock bits).
module tb_uart_tx_serializer;

  localparam int CLK_HZ  = 10_000_000;
  localparam int BAUD_HZ = 115_200;
  localparam int SR      = 16;
  localparam int DIV     = 5;            // round(10e6 / (115200*16)) = round(5.43)
  localparam int BIT     = SR * DIV;
  localparam int FRAME   = 10 * BIT;
  localparam int PERIOD  = FRAME + 1;    // back-to-back spacing with the 1-cycle idle gap

  logic clk_in;
  logic rst_in;
  int   n_vec;
  int   n_err;
  int   cur_t;

  uart_tx_serializer_if bus ();

  uart_tx_serializer #(
    .BAUDRATE_HZ (BAUD_HZ),
    .CLK_HZ      (CLK_HZ),
    .SAMPLE_RATE (SR)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Line level t clocks after the acceptance edge of a frame carrying d.
  function automatic logic exp_tx(input logic [7:0] d, input int t);
    int b;
    b = t / BIT;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: got %b expected %b", tag, cur_t, obs, exp);
    end
  endtask

  task automatic check_at(input logic [7:0] d, input int t);
    cur_t = t;
    chk("tx_out", bus.tx_out, exp_tx(d, t));
    chk("busy_out", bus.busy_out, t < FRAME);
    chk("tick_out", bus.tick_out, (t % DIV) == DIV - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur_t = -i;
      chk("idle_tx", bus.tx_out, 1'b1);
      chk("idle_busy", bus.busy_out, 1'b0);
      @(negedge clk_in);
    end
  endtask

  // Called just after a negedge; reset asserted between edges must act at once.
  task automatic do_reset();
    #2 rst_in = 1'b1;
    #1;
    cur_t = 0;
    chk("rst_tx", bus.tx_out, 1'b1);
    chk("rst_busy", bus.busy_out, 1'b0);
    chk("rst_tick", bus.tick_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int n = 0; n <= 3 * DIV; n++) begin
      cur_t = n;
      chk("rst_tick_cadence", bus.tick_out, (n % DIV) == DIV - 1);
      chk("rst_idle_tx", bus.tx_out, 1'b1);
      @(negedge clk_in);
    end
  endtask

  // Sends d, scrambling data_in mid-frame; optionally pulses enable at pulse_at.
  task automatic run_frame(input logic [7:0] d, input int pulse_at,
                           input logic [7:0] pulse_d, input int tail);
    bus.data_in   = d;
    bus.enable_in = 1'b1;
    @(negedge clk_in);
    bus.enable_in = 1'b0;
    for (int t = 0; t < FRAME + tail; t++) begin
      check_at(d, t);
      if (t == pulse_at) begin
        bus.enable_in = 1'b1;
        bus.data_in   = pulse_d;
      end else begin
        bus.enable_in = 1'b0;
        bus.data_in   = 8'($urandom);
      end
      @(negedge clk_in);
    end
    bus.enable_in = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    n_vec = 0;
    n_err = 0;
    cur_t = 0;
    rst_in = 1'b0;
    bus.enable_in = 1'b0;
    bus.data_in   = 8'h00;

    do_reset();

    run_frame(8'h93, -1, 8'h00, 20);
    idle(200);
    run_frame(8'hC3, -1, 8'h00, 5);

    // Enable pulse mid-frame must be dropped; the tail shows no second frame.
    run_frame(8'h93, (2000 * BIT) / 864, 8'h55, 3 * BIT);

    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(1, 30));
      d = 8'($urandom);
      run_frame(d, -1, 8'h00, 2);
    end

    // enable_in held high: frames every FRAME+1 clocks with a 1-cycle busy gap.
    bus.data_in   = 8'hFF;
    bus.enable_in = 1'b1;
    @(negedge clk_in);
    for (int t = 0; t < 3 * PERIOD; t++) begin
      check_at(8'hFF, t % PERIOD);
      if (t == 3 * PERIOD - 3) bus.enable_in = 1'b0;
      @(negedge clk_in);
    end
    bus.enable_in = 1'b0;
    idle(5);

    // Abort during data bit 3, then a full frame must follow cleanly.
    d = 8'($urandom);
    bus.data_in   = d;
    bus.enable_in = 1'b1;
    @(negedge clk_in);
    bus.enable_in = 1'b0;
    for (int t = 0; t < 4 * BIT + BIT / 2; t++) begin
      check_at(d, t);
      @(negedge clk_in);
    end
    do_reset();
    d = 8'($urandom);
    run_frame(d, -1, 8'h00, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
